// File: rtl/fft16_result_reader_if.sv
// ---------------------------------------------------------------------------
// fft16_result_reader_if
//
// Purpose : Bundles the frame-capture side and the word-stream side of the
//           FFT16 result reader into one interface.
//
// Signals :
//   in_valid   frame on i0..i15 is valid this cycle        (master -> slave)
//   in_ready   reader can accept a frame this cycle        (slave  -> master)
//   i0..i15    packed complex words, [63:32] re, [31:0] im (master -> slave)
//   out_valid  current word valid                          (slave  -> master)
//   out_ready  downstream accepts the current word         (master -> slave)
//   out_real   real part of the current word               (slave  -> master)
//   out_imag   imaginary part of the current word          (slave  -> master)
//   out_idx    frequency index of the current word         (slave  -> master)
//   out_last   current word is the 16th of the frame       (slave  -> master)
//   ovf        sticky dropped-frame flag                   (slave  -> master)
//
// Modports:
//   master  environment side (FFT stage plus downstream consumer)
//   slave   the reader itself
// ---------------------------------------------------------------------------
interface fft16_result_reader_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] i0,  i1,  i2,  i3,  i4,  i5,  i6,  i7;
  logic [63:0] i8,  i9,  i10, i11, i12, i13, i14, i15;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_real;
  logic [31:0] out_imag;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        ovf;

  modport master (
    output in_valid,
    output i0, i1, i2, i3, i4, i5, i6, i7,
    output i8, i9, i10, i11, i12, i13, i14, i15,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_real,
    input  out_imag,
    input  out_idx,
    input  out_last,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  i0, i1, i2, i3, i4, i5, i6, i7,
    input  i8, i9, i10, i11, i12, i13, i14, i15,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_real,
    output out_imag,
    output out_idx,
    output out_last,
    output ovf
  );
endinterface

// File: rtl/fft16_result_reader.sv
// ---------------------------------------------------------------------------
// fft16_result_reader
//
// Purpose : Captures one 16-point FFT result frame (16 packed complex words)
//           in a single cycle, then streams the words out one per transfer
//           over a valid/ready handshake, split into real and imaginary parts.
//
// Ports   :
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   fft16_result_reader_if.slave (frame input, word stream, ovf flag)
//
// Build option:
//   FFT16_RD_BITREV_EN  when defined, words leave in bit-reversed index
//                       order (0,8,4,12,...,15); otherwise natural order 0..15.
//                       out_last always marks the 16th word of the frame.
// ---------------------------------------------------------------------------
module fft16_result_reader (
  input  logic                  clk,
  input  logic                  rst,
  fft16_result_reader_if.slave  bus
);

  // -------------------------------------------------------------------------
  // FSM encoding
  // -------------------------------------------------------------------------
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        ovf_q,   ovf_d;
  logic [63:0] buf_q [16];

  logic [63:0] frame_in [16];
  logic        capture;
  logic [3:0]  sel;
  logic [63:0] word;

  // Flatten the individually named result ports into an indexable frame.
  assign frame_in[0]  = bus.i0;
  assign frame_in[1]  = bus.i1;
  assign frame_in[2]  = bus.i2;
  assign frame_in[3]  = bus.i3;
  assign frame_in[4]  = bus.i4;
  assign frame_in[5]  = bus.i5;
  assign frame_in[6]  = bus.i6;
  assign frame_in[7]  = bus.i7;
  assign frame_in[8]  = bus.i8;
  assign frame_in[9]  = bus.i9;
  assign frame_in[10] = bus.i10;
  assign frame_in[11] = bus.i11;
  assign frame_in[12] = bus.i12;
  assign frame_in[13] = bus.i13;
  assign frame_in[14] = bus.i14;
  assign frame_in[15] = bus.i15;

  // A frame is only taken while idle; an offer during SEND is an overflow.
  assign capture = (state_q == ST_IDLE) && bus.in_valid;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_SEND;
          cnt_d   = 4'd0;
        end
      end
      ST_SEND: begin
        // Busy: any offered frame is dropped and remembered as overflow,
        // including one offered on the same edge as the final transfer.
        if (bus.in_valid) begin
          ovf_d = 1'b1;
        end
        if (bus.out_ready) begin
          if (cnt_q == 4'd15) begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // -------------------------------------------------------------------------
  // Frame buffer: all 16 words written in parallel on capture. Reset clears
  // it so the data outputs read zero out of reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        buf_q[k] <= 64'd0;
      end
    end else if (capture) begin
      for (int k = 0; k < 16; k++) begin
        buf_q[k] <= frame_in[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Word selection. cnt is the position in the stream; sel is the buffer
  // slot (= frequency index) emitted at that position.
  // -------------------------------------------------------------------------
`ifdef FFT16_RD_BITREV_EN
  assign sel = {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]};
`else
  assign sel = cnt_q;
`endif

  // Outputs depend only on registered state, so out_ready has no
  // combinational path to the data outputs.
  assign word          = buf_q[sel];
  assign bus.out_real  = word[63:32];
  assign bus.out_imag  = word[31:0];
  assign bus.out_idx   = sel;
  assign bus.out_last  = (cnt_q == 4'd15);
  assign bus.out_valid = (state_q == ST_SEND);
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fft16_result_reader.sv
// ---------------------------------------------------------------------------
// tb_fft16_result_reader
//
// Self-checking bench for fft16_result_reader. The reference model is the
// frame array plus the expected emission order (natural or bit-reversed);
// the n-th word on the stream must equal frame[order[n]].
// ---------------------------------------------------------------------------
module tb_fft16_result_reader;

  typedef logic [63:0] frame_t [16];

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft16_result_reader_if tif ();

  fft16_result_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     order [16];
  frame_t frame;
  frame_t other;

  // One cycle: wait for the active edge, then settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ports(input frame_t f);
    tif.i0  = f[0];  tif.i1  = f[1];  tif.i2  = f[2];  tif.i3  = f[3];
    tif.i4  = f[4];  tif.i5  = f[5];  tif.i6  = f[6];  tif.i7  = f[7];
    tif.i8  = f[8];  tif.i9  = f[9];  tif.i10 = f[10]; tif.i11 = f[11];
    tif.i12 = f[12]; tif.i13 = f[13]; tif.i14 = f[14]; tif.i15 = f[15];
  endtask

  task automatic random_frame();
    for (int k = 0; k < 16; k++) begin
      frame[k] = {$urandom(), $urandom()};
    end
  endtask

  // Expected {out_valid, out_idx, out_real, out_imag, out_last} at stream
  // position pos while the frame is being sent.
  function automatic logic [69:0] exp_word(input int pos);
    int         k;
    logic [3:0] ki;
    k  = order[pos];
    ki = 4'(k);
    return {1'b1, ki, frame[k], (pos == 15)};
  endfunction

  function automatic logic [69:0] got_word();
    return {tif.out_valid, tif.out_idx, tif.out_real, tif.out_imag, tif.out_last};
  endfunction

  // Present frame on the ports for one cycle while idle.
  task automatic capture_frame();
    drive_ports(frame);
    tif.in_valid = 1'b1;
    step();
    tif.in_valid = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [6:0] got;
    rst = 1'b1;
    tif.in_valid  = 1'b0;
    tif.out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      got = {tif.in_ready, tif.out_valid, tif.ovf, tif.out_idx};
      checks++;
      if (got !== 7'b100_0000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got={rdy,vld,ovf,idx}=%b want=1000000", c, got);
      end
      step();
    end
    checks++;
    if ({tif.out_real, tif.out_imag} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", {tif.out_real, tif.out_imag});
    end
    $display("test_reset done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_natural();
    int pos = 0;
    int cyc = 0;
    for (int k = 0; k < 16; k++) begin
      frame[k] = {32'(32'h0000_0100 * k), 32'(32'hFFFF_FF00 - k)};
    end
    tif.out_ready = 1'b1;
    capture_frame();
    while (pos < 16 && cyc < 100) begin
      checks++;
      if (got_word() !== exp_word(pos)) begin
        errors++;
        $display("FAIL natural_word pos=%0d got=%h want=%h", pos, got_word(), exp_word(pos));
      end
      pos++;
      step();
      cyc++;
    end
    checks++;
    if (pos < 16) begin
      errors++;
      $display("FAIL natural_timeout got=%0d words want=16", pos);
    end
    checks++;
    if ({tif.in_ready, tif.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL natural_idle_after got={rdy,vld}=%b want=10", {tif.in_ready, tif.out_valid});
    end
    $display("test_natural done words=%0d", pos);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_backpressure();
    int   pos = 0;
    int   cyc = 0;
    logic rdy;
    random_frame();
    tif.out_ready = 1'b0;
    capture_frame();
    while (pos < 16 && cyc < 200) begin
      rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      tif.out_ready = rdy;
      // Stalled cycles must keep showing the same (not yet taken) word.
      checks++;
      if (got_word() !== exp_word(pos)) begin
        errors++;
        $display("FAIL bp_word cyc=%0d pos=%0d got=%h want=%h", cyc, pos, got_word(), exp_word(pos));
      end
      if (rdy) pos++;
      step();
      cyc++;
    end
    checks++;
    if (pos < 16 || tif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_complete got=%0d words vld=%b want=16 words vld=0", pos, tif.out_valid);
    end
    tif.out_ready = 1'b0;
    $display("test_backpressure done cycles=%0d", cyc);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      int   pos = 0;
      int   cyc = 0;
      logic rdy;
      random_frame();
      tif.out_ready = 1'($urandom_range(0, 1));
      capture_frame();
      while (pos < 16 && cyc < 300) begin
        rdy = 1'($urandom_range(0, 1));
        tif.out_ready = rdy;
        checks++;
        if (got_word() !== exp_word(pos)) begin
          errors++;
          $display("FAIL rand_word f=%0d pos=%0d got=%h want=%h", f, pos, got_word(), exp_word(pos));
        end
        if (rdy) pos++;
        step();
        cyc++;
      end
      checks++;
      if (pos < 16 || tif.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_complete f=%0d got=%0d words rdy=%b want=16 rdy=1", f, pos, tif.in_ready);
      end
      $display("test_random frame %0d done cycles=%0d", f, cyc);
    end
    tif.out_ready = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [2:0] ctl;
    // Frame A, then frame B accepted in the first idle cycle.
    random_frame();
    tif.out_ready = 1'b1;
    capture_frame();
    for (int pos = 0; pos < 16; pos++) begin
      checks++;
      if (got_word() !== exp_word(pos)) begin
        errors++;
        $display("FAIL b2b_a_word pos=%0d got=%h want=%h", pos, got_word(), exp_word(pos));
      end
      step();
    end
    checks++;
    if (tif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got=%b want=1", tif.in_ready);
    end
    random_frame();
    capture_frame();
    for (int pos = 0; pos < 16; pos++) begin
      checks++;
      if (got_word() !== exp_word(pos)) begin
        errors++;
        $display("FAIL b2b_b_word pos=%0d got=%h want=%h", pos, got_word(), exp_word(pos));
      end
      // Offer a new frame on the same edge as the final transfer: busy.
      if (pos == 15) begin
        for (int k = 0; k < 16; k++) other[k] = ~frame[k];
        drive_ports(other);
        tif.in_valid = 1'b1;
      end
      step();
    end
    tif.in_valid = 1'b0;
    ctl = {tif.in_ready, tif.out_valid, tif.ovf};
    checks++;
    if (ctl !== 3'b101) begin
      errors++;
      $display("FAIL b2b_last_edge got={rdy,vld,ovf}=%b want=101", ctl);
    end
    checks++;
    if ({tif.out_real, tif.out_imag} !== frame[0]) begin
      errors++;
      $display("FAIL b2b_buf_kept got=%h want=%h", {tif.out_real, tif.out_imag}, frame[0]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({tif.ovf, tif.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_ovf_clear got={ovf,rdy}=%b want=01", {tif.ovf, tif.in_ready});
    end
    tif.out_ready = 1'b0;
    $display("test_back_to_back done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_overflow();
    random_frame();
    for (int k = 0; k < 16; k++) other[k] = 64'hDEAD_BEEF_0000_0001;
    tif.out_ready = 1'b1;
    capture_frame();
    for (int pos = 0; pos < 16; pos++) begin
      checks++;
      if (got_word() !== exp_word(pos)) begin
        errors++;
        $display("FAIL ovf_word pos=%0d got=%h want=%h", pos, got_word(), exp_word(pos));
      end
      checks++;
      if (tif.ovf !== (pos > 5)) begin
        errors++;
        $display("FAIL ovf_flag pos=%0d got=%b want=%b", pos, tif.ovf, (pos > 5));
      end
      if (pos == 5) begin
        drive_ports(other);
        tif.in_valid = 1'b1;
      end
      step();
      tif.in_valid = 1'b0;
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({tif.ovf, tif.out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL ovf_sticky cyc=%0d got={ovf,vld}=%b want=10", c, {tif.ovf, tif.out_valid});
      end
      step();
    end
    tif.out_ready = 1'b0;
    $display("test_overflow done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [6:0] ctl;
    random_frame();
    tif.out_ready = 1'b1;
    capture_frame();
    for (int pos = 0; pos < 7; pos++) begin
      checks++;
      if (got_word() !== exp_word(pos)) begin
        errors++;
        $display("FAIL mid_word pos=%0d got=%h want=%h", pos, got_word(), exp_word(pos));
      end
      step();
    end
    rst = 1'b1;
    tif.out_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ctl = {tif.in_ready, tif.out_valid, tif.ovf, tif.out_idx};
      checks++;
      if (ctl !== 7'b100_0000) begin
        errors++;
        $display("FAIL mid_abort cyc=%0d got={rdy,vld,ovf,idx}=%b want=1000000", c, ctl);
      end
      step();
    end
    random_frame();
    tif.out_ready = 1'b1;
    capture_frame();
    for (int pos = 0; pos < 16; pos++) begin
      checks++;
      if (got_word() !== exp_word(pos)) begin
        errors++;
        $display("FAIL mid_new_word pos=%0d got=%h want=%h", pos, got_word(), exp_word(pos));
      end
      step();
    end
    tif.out_ready = 1'b0;
    $display("test_reset_mid done");
  endtask

  // -------------------------------------------------------------------------
  initial begin
    tif.in_valid  = 1'b0;
    tif.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) other[k] = 64'd0;
    drive_ports(other);

    // Emission order: natural, or index bits mirrored.
    for (int n = 0; n < 16; n++) begin
`ifdef FFT16_RD_BITREV_EN
      int r = 0;
      for (int b = 0; b < 4; b++) begin
        if (((n >> b) & 1) == 1) r += (8 >> b);
      end
      order[n] = r;
`else
      order[n] = n;
`endif
    end

    test_reset();
    test_natural();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_overflow();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft16_result_reader.md
# fft16_result_reader

Consumer side of the FFT16 parallel result interface. It captures one 16-point frame of packed complex words (o0..o15 of the FFT datapath) in a single cycle, then streams the words out one at a time over a valid/ready handshake as separate real and imaginary buffers. It sits between the FFT16 stage and any downstream sequential consumer: the next stage, a memory writer, or a testbench checker.

## Interface
- No parameters. Widths are fixed by the FFT16 result format.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  frame on i0..i15 is valid this cycle.
- `in_ready`  out  1  reader can accept a frame this cycle.
- `i0`..`i15`  in  64 each  packed complex result: [63:32] real, [31:0] imag, both two's complement.
- `out_valid`  out  1  out_real/out_imag/out_idx hold a valid word.
- `out_ready`  in  1  downstream accepts the word this cycle.
- `out_real`  out  32  real part of the current word.
- `out_imag`  out  32  imaginary part of the current word.
- `out_idx`  out  4  frequency index of the current word (which i-port it came from).
- `out_last`  out  1  current word is the 16th of the frame.
- `ovf`  out  1  sticky flag: a frame was offered while busy and was dropped.

## Operation
- FSM states:
  - IDLE (reset state): `in_ready`=1, `out_valid`=0.
  - SEND: `in_ready`=0, `out_valid`=1.
- IDLE with `in_valid`=1:
  - All 16 inputs are copied into a 16x64 frame buffer.
  - Sequence counter `cnt` is set to 0.
  - Next state is SEND.
- SEND:
  - Current word is buf[sel(cnt)]. out_real = [63:32], out_imag = [31:0], out_idx = sel(cnt).
  - Outputs are driven combinationally from registered state.
  - `out_last` = (cnt == 15).
- Transfer occurs when `out_valid` && `out_ready`.
  - On transfer with cnt < 15: cnt increments.
  - On transfer with cnt == 15: cnt wraps to 0 and the FSM returns to IDLE.
- While `out_ready`=0, outputs and `cnt` hold unchanged.
- In SEND, `in_valid`=1 sets `ovf`=1. The offered frame is ignored and the buffer is unchanged.
- `ovf` clears only on `rst`.
- Data passes through bit-exact. No scaling, rounding or sign handling.
- Index mapping: sel(cnt) = cnt in natural order (see Configuration).

## Timing
- Reset values: state=IDLE, cnt=0, `in_ready`=1, `out_valid`=0, `out_last`=0, `ovf`=0, `out_idx`=0.
  - `out_real` and `out_imag` read 0, because the buffer is cleared by reset.
- `rst` mid-frame aborts the frame on the same edge. Remaining words are discarded and no further `out_valid` is raised.
- Frame accepted at edge N: `out_valid`=1 from edge N, with word 0 visible in the cycle after edge N.
- Minimum frame period is 17 cycles (1 capture + 16 transfers) with `out_ready` held at 1.
- `in_ready` is 0 in the cycle after the last transfer's edge? No: the last transfer edge returns the FSM to IDLE, so `in_ready`=1 in the very next cycle. There is no same-cycle capture-during-send overlap.
- `in_valid` asserted on the same edge as the last transfer (FSM still in SEND) counts as busy. It sets `ovf` and is dropped.
- Single cycle per word; no combinational path from `out_ready` to `out_real`/`out_imag`/`out_idx`.

## Configuration
- `FFT16_RD_BITREV_EN` defined: sel(cnt) = bit-reverse of cnt ({cnt[0],cnt[1],cnt[2],cnt[3]}). `out_idx` reports the reversed index. Order is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
- Undefined: sel(cnt) = cnt. Order is 0..15.
- `out_last` is tied to cnt==15 in both builds.

## Test plan
- Reset then idle:
  - Stimulus: `rst` for 2 cycles, then `in_valid`=0.
  - Required: `in_ready`=1, `out_valid`=0, `ovf`=0, `out_idx`=0 for 10 cycles.
- Natural order, no stall:
  - Stimulus: ik = {32'h0000_0100*k, 32'hFFFF_FF00 - k}, `out_ready`=1.
  - Required: 16 words with out_idx=0..15 and matching real/imag; `out_last` only on idx 15; `in_ready`=1 in the cycle after the 16th transfer.
- Backpressure:
  - Stimulus: `out_ready` toggled 1,0,0,1,…
  - Required: while `out_ready`=0, outputs remain stable; every word is delivered exactly once and in order.
- Overflow:
  - Stimulus: second frame (all ports 64'hDEAD_BEEF_0000_0001) on `in_valid` at transfer 5 of frame 1.
  - Required: `ovf`=1 from the next cycle; frame-1 data is unchanged; `ovf` stays 1 until `rst`.
- Reset mid-frame:
  - Stimulus: `rst` pulsed after transfer 7.
  - Required: `out_valid`=0 and `in_ready`=1 the next cycle; a new frame then starts at idx 0.
- `FFT16_RD_BITREV_EN` build:
  - Stimulus: frame where ik real = k.
  - Required: out_real sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, with out_idx equal to out_real.
